op_sequencer: RTL and testbench

OP_SEQUENCER -- requirements
Module: op_sequencer

---
 rtl/op_sequencer.sv | 127 ++++++++++++
 tb/tb_op_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/op_sequencer.sv
// Table-driven accumulator sequencer: executes a programmable opcode table against
// R2 (accumulator) and R1 (operand) for a bounded or free-running number of steps.
module op_sequencer #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NSTEPS = 4,
  localparam int unsigned SW    = $clog2(NSTEPS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in1,
  input  logic             load,
  input  logic [7:0]       run_len,
  input  logic             prog_we,
  input  logic [3:0]       prog_addr,
  input  logic [2:0]       prog_op,
  output logic [WIDTH-1:0] out1,
  output logic [SW-1:0]    step,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_r1, r_r2, w_r2_next, w_sum, w_diff;
  logic [SW-1:0]    r_step;
  logic [7:0]       r_rem;
  logic             r_ovf, r_done, w_ovf_step;
  logic [2:0]       r_table [NSTEPS];
  logic [2:0]       w_op;
  logic             w_exec, w_last, w_addr_ok;

  assign w_exec    = (r_state == StRun) && !load;
  // remaining==0 while running means free-run, so only an explicit 1 finishes
  assign w_last    = w_exec && (r_rem == 8'd1);
  assign w_addr_ok = (prog_addr >> SW) == 4'd0;
  assign w_op      = r_table[r_step];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (load)        w_state_next = StRun;
    else if (w_last) w_state_next = StIdle;
  end

  // FSM outputs
  always_comb begin
    busy = (r_state == StRun);
  end

  // ALU
  always_comb begin
    w_sum      = r_r2 + r_r1;
    w_diff     = r_r2 - r_r1;
    w_r2_next  = r_r2;
    w_ovf_step = 1'b0;
    case (w_op)
      3'b000: begin
        w_r2_next  = -r_r1;
        w_ovf_step = (r_r1 == MinVal);
      end
      3'b001: w_r2_next = r_r2 & r_r1;
      3'b010: begin
        w_r2_next  = -r_r2;
        w_ovf_step = (r_r2 == MinVal);
      end
      3'b011: begin
        w_r2_next  = w_sum;
        w_ovf_step = (r_r2[WIDTH-1] == r_r1[WIDTH-1]) && (w_sum[WIDTH-1] != r_r2[WIDTH-1]);
      end
      3'b100: begin
        w_r2_next  = w_diff;
        w_ovf_step = (r_r2[WIDTH-1] != r_r1[WIDTH-1]) && (w_diff[WIDTH-1] != r_r2[WIDTH-1]);
      end
      3'b101:  w_r2_next = r_r2 | r_r1;
      3'b110:  w_r2_next = r_r2 ^ r_r1;
      default: w_r2_next = r_r2;
    endcase
  end

  // Datapath and opcode table
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_r1   <= '0;
      r_r2   <= '0;
      r_step <= '0;
      r_rem  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
      for (int unsigned i = 0; i < NSTEPS; i++) r_table[i] <= 3'(i % 4);
    end else begin
      if (load) begin
        r_r1   <= in1;
        r_r2   <= '0;
        r_step <= '0;
        r_rem  <= run_len;
        r_ovf  <= 1'b0;
        r_done <= 1'b0;
      end else if (w_exec) begin
        r_r2   <= w_r2_next;
        r_ovf  <= r_ovf | w_ovf_step;
        r_step <= r_step + 1'b1;
        if (r_rem != 8'd0) r_rem <= r_rem - 8'd1;
        r_done <= w_last;
      end else begin
        r_done <= 1'b0;
      end
      // Executing op above read the pre-write entry
      if (prog_we && w_addr_ok) r_table[prog_addr[SW-1:0]] <= prog_op;
    end
  end

  assign out1 = r_r2;
  assign step = r_step;
  assign done = r_done;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: integer-level reference model checked every cycle, plus
// hand-computed directed sequences and randomized load/program/reset traffic.
module tb_op_sequencer;

  logic        clk;
  logic        reset_n;
  logic [31:0] in1;
  logic        load;
  logic [7:0]  run_len;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [2:0]  prog_op;
  logic [31:0] out1;
  logic [1:0]  step;
  logic        busy;
  logic        done;
  logic        ovf;

  op_sequencer #(.WIDTH(32), .NSTEPS(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in1      (in1),
    .load     (load),
    .run_len  (run_len),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_op  (prog_op),
    .out1     (out1),
    .step     (step),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: signed 64-bit arithmetic, overflow = result not representable in 32 bits
  localparam longint MaxS = 64'sd2147483647;
  localparam longint MinS = -64'sd2147483648;

  bit [31:0] m_r1, m_r2;
  int        m_step, m_rem, m_op;
  bit        m_busy, m_done, m_ovf, m_live;
  int        m_tab [4];
  longint    m_a, m_b, m_s;

  initial m_live = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_r1 = 0; m_r2 = 0; m_step = 0; m_rem = 0;
      m_busy = 0; m_done = 0; m_ovf = 0;
      for (int i = 0; i < 4; i++) m_tab[i] = i % 4;
    end else begin
      m_op = m_tab[m_step];
      if (load) begin
        m_r1 = in1; m_r2 = 0; m_step = 0; m_rem = int'(run_len);
        m_ovf = 0; m_done = 0; m_busy = 1;
      end else if (m_busy) begin
        m_a = longint'($signed(m_r2));
        m_b = longint'($signed(m_r1));
        case (m_op)
          0:       m_s = -m_b;
          1:       m_s = m_a & m_b;
          2:       m_s = -m_a;
          3:       m_s = m_a + m_b;
          4:       m_s = m_a - m_b;
          5:       m_s = m_a | m_b;
          6:       m_s = m_a ^ m_b;
          default: m_s = m_a;
        endcase
        if (m_s > MaxS || m_s < MinS) m_ovf = 1;
        m_r2   = m_s[31:0];
        m_step = (m_step + 1) % 4;
        m_done = 0;
        if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end else begin
        m_done = 0;
      end
      if (prog_we && prog_addr < 4) m_tab[prog_addr] = int'(prog_op);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_live && reset_n) begin
      chk("out1", out1, m_r2);
      chk("step", step, m_step);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("ovf",  ovf,  m_ovf);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] len);
    load = 1'b1; in1 = v; run_len = len;
    tick();
    load = 1'b0;
  endtask

  logic [31:0] e33 [4];

  initial begin
    e33 = '{32'hFFFF_FFFB, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0004};
    in1 = '0; load = 1'b0; run_len = '0; prog_we = 1'b0; prog_addr = '0; prog_op = '0;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    #10;
    @(negedge clk);
    reset_n = 1'b1;
    m_live  = 1'b1;
    chk("rst_out1", out1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step, 0);
    chk("rst_ovf",  ovf,  0);

    // Bounded run on the default table
    do_load(32'd5, 8'd4);
    chk("r33_load_out1", out1, 0);
    chk("r33_load_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("r33_seq", out1, e33[k]);
    end
    chk("r33_done", done, 1);
    chk("r33_busy", busy, 0);
    tick();
    chk("r33_done_clr", done, 0);
    chk("r33_hold", out1, 32'h4);

    // Free run wraps the step index
    do_load(32'd5, 8'd0);
    repeat (4) tick();
    chk("r34_wrap_step", step, 0);
    chk("r34_busy", busy, 1);
    tick();
    chk("r34_fifth", out1, 32'hFFFF_FFFB);
    chk("r34_nodone", done, 0);

    // Overflow via reprogrammed add entries
    prog_we = 1'b1; prog_addr = 4'd0; prog_op = 3'b011;
    tick();
    prog_addr = 4'd1;
    tick();
    prog_we = 1'b0;
    do_load(32'h7FFF_FFFF, 8'd2);
    tick();
    chk("r35_s0", out1, 32'h7FFF_FFFF);
    chk("r35_ovf0", ovf, 0);
    tick();
    chk("r35_s1", out1, 32'hFFFF_FFFE);
    chk("r35_ovf1", ovf, 1);
    chk("r35_done", done, 1);
    repeat (3) tick();
    chk("r35_sticky", ovf, 1);
    do_load(32'd1, 8'd1);
    chk("r35_clr", ovf, 0);

    // Reload mid-run aborts without a done pulse
    tick();
    do_load(32'd3, 8'd4);
    repeat (2) tick();
    do_load(32'd9, 8'd4);
    chk("r36_out1", out1, 0);
    chk("r36_step", step, 0);
    repeat (3) tick();
    chk("r36_nodone", done, 0);
    tick();
    chk("r36_done", done, 1);
    chk("r36_busy", busy, 0);

    // Asynchronous reset mid-run, then an out-of-range write
    do_load(32'd5, 8'd4);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("r37_out1", out1, 0);
    chk("r37_busy", busy, 0);
    chk("r37_step", step, 0);
    #1 reset_n = 1'b1;
    prog_we = 1'b1; prog_addr = 4'd4; prog_op = 3'b111;
    tick();
    prog_we = 1'b0;
    do_load(32'd5, 8'd4);
    tick();
    chk("r37_tab0", out1, 32'hFFFF_FFFB);
    tick();
    chk("r37_tab1", out1, 32'h1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      load    = ($urandom_range(0, 11) == 0);
      run_len = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
      case ($urandom_range(0, 5))
        0:       in1 = 32'h8000_0000;
        1:       in1 = 32'h7FFF_FFFF;
        2:       in1 = 32'hFFFF_FFFF;
        default: in1 = $urandom;
      endcase
      prog_we   = ($urandom_range(0, 3) == 0);
      prog_addr = 4'($urandom_range(0, 15));
      prog_op   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      tick();
    end

    load = 1'b0; prog_we = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
